// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared types for the scoreboard hazard unit: stall cause encoding,
// register index type and the countdown counter width helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    NONE        = 2'b00,
    LOAD_USE    = 2'b01,
    BRANCH_DATA = 2'b10
  } stall_cause_t;

  localparam int DEF_RW = 5;
  typedef logic [DEF_RW-1:0] reg_idx_t;

  // One spare bit above the largest load value keeps the compare headroom simple.
  function automatic int cnt_width(input int load_lat, input int br_extra);
    return $clog2(load_lat + br_extra + 1) + 1;
  endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// ID-stage decode / hazard-control bundle between the decoder side (master)
// and the hazard unit (slave).
interface scoreboard_hazard_unit_if #(
  parameter int RW     = 5,
  parameter int STAT_W = 32
);
  logic              id_valid;
  logic [RW-1:0]     id_rs;
  logic [RW-1:0]     id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_branch;
  logic              id_wr_en;
  logic [RW-1:0]     id_rd;
  logic              id_mem_read;
  logic              pipe_hold;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_flush;
  logic [1:0]        stall_cause;
  logic [STAT_W-1:0] ld_stall_cnt;
  logic [STAT_W-1:0] br_stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
           id_wr_en, id_rd, id_mem_read, pipe_hold,
    input  pc_write, if_id_write, id_ex_flush, stall_cause,
           ld_stall_cnt, br_stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
           id_wr_en, id_rd, id_mem_read, pipe_hold,
    output pc_write, if_id_write, id_ex_flush, stall_cause,
           ld_stall_cnt, br_stall_cnt
  );
endinterface

// File: rtl/scoreboard_hazard_unit_sb_entry.sv
// One scoreboard entry: ALU-consumer and branch-consumer countdowns plus a
// flag remembering whether the last writer was a load.
module sb_entry
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int BR_EXTRA = 1,
  parameter int CW       = cnt_width(1, 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          set,
  input  logic          set_load,
  output logic [CW-1:0] alu_cnt,
  output logic [CW-1:0] br_cnt,
  output logic          load_flag
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_cnt   <= '0;
      br_cnt    <= '0;
      load_flag <= 1'b0;
    end else if (set) begin
      // A new writer overrides any countdown still in flight.
      alu_cnt   <= set_load ? CW'(LOAD_LAT) : '0;
      br_cnt    <= set_load ? CW'(LOAD_LAT + BR_EXTRA) : CW'(BR_EXTRA);
      load_flag <= set_load;
    end else if (!hold) begin
      if (alu_cnt != '0) alu_cnt <= alu_cnt - CW'(1);
      if (br_cnt != '0)  br_cnt  <= br_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// ID-stage hazard/stall unit built on a per-register countdown scoreboard.
// Optional stall statistics are built when HAZARD_STALL_STATS_EN is defined.
module scoreboard_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int RW       = $clog2(NUM_REGS),
  parameter int LOAD_LAT = 1,
  parameter int BR_EXTRA = 1,
  parameter int STAT_W   = 32
) (
  input logic               clk,
  input logic               rst_n,
  scoreboard_hazard_unit_if.slave bus
);

  localparam int CW = cnt_width(LOAD_LAT, BR_EXTRA);

  logic [CW-1:0] alu_cnt [NUM_REGS];
  logic [CW-1:0] br_cnt  [NUM_REGS];
  logic          ld_flag [NUM_REGS];
  logic [CW-1:0] rs_cnt, rt_cnt;
  logic          rs_blk, rt_blk, blk_load, stall, issue;
  stall_cause_t  cause;

  // r0 is hard-wired zero and therefore never pending.
  assign alu_cnt[0] = '0;
  assign br_cnt[0]  = '0;
  assign ld_flag[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NUM_REGS; r++) begin : g_entry
      sb_entry #(
        .LOAD_LAT (LOAD_LAT),
        .BR_EXTRA (BR_EXTRA),
        .CW       (CW)
      ) u_entry (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (bus.pipe_hold),
        .set       (issue && bus.id_wr_en && (bus.id_rd == RW'(r))),
        .set_load  (bus.id_mem_read),
        .alu_cnt   (alu_cnt[r]),
        .br_cnt    (br_cnt[r]),
        .load_flag (ld_flag[r])
      );
    end
  endgenerate

  always_comb begin
    rs_cnt   = bus.id_branch ? br_cnt[bus.id_rs] : alu_cnt[bus.id_rs];
    rt_cnt   = bus.id_branch ? br_cnt[bus.id_rt] : alu_cnt[bus.id_rt];
    rs_blk   = bus.id_valid && bus.id_use_rs && (bus.id_rs != '0) && (rs_cnt != '0);
    rt_blk   = bus.id_valid && bus.id_use_rt && (bus.id_rt != '0) && (rt_cnt != '0);
    stall    = rs_blk || rt_blk;
    // A load still in flight dominates the cause even for a branch consumer.
    blk_load = (rs_blk && ld_flag[bus.id_rs]) || (rt_blk && ld_flag[bus.id_rt]);
    cause    = !stall ? NONE : (blk_load ? LOAD_USE : BRANCH_DATA);
  end

  assign issue           = bus.id_valid && !stall && !bus.pipe_hold;
  assign bus.pc_write    = !stall;
  assign bus.if_id_write = !stall;
  assign bus.id_ex_flush = stall;
  assign bus.stall_cause = cause;

`ifdef HAZARD_STALL_STATS_EN
  logic [STAT_W-1:0] ld_q, br_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_q <= '0;
      br_q <= '0;
    end else if (!bus.pipe_hold) begin
      if (cause == LOAD_USE && ld_q != '1)    ld_q <= ld_q + STAT_W'(1);
      if (cause == BRANCH_DATA && br_q != '1) br_q <= br_q + STAT_W'(1);
    end
  end

  assign bus.ld_stall_cnt = ld_q;
  assign bus.br_stall_cnt = br_q;
`else
  assign bus.ld_stall_cnt = '0;
  assign bus.br_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench: table of ID-stage vectors on a LOAD_LAT=1 unit, plus
// hand sequences for a LOAD_LAT=3 unit under pipe_hold and reset mid-stall.
module tb_scoreboard_hazard_unit;

`ifdef HAZARD_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scoreboard_hazard_unit_if #(.RW(5), .STAT_W(32)) ifa ();
  scoreboard_hazard_unit_if #(.RW(5), .STAT_W(32)) ifb ();

  scoreboard_hazard_unit #(.NUM_REGS(32), .RW(5), .LOAD_LAT(1), .BR_EXTRA(1), .STAT_W(32))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  scoreboard_hazard_unit #(.NUM_REGS(32), .RW(5), .LOAD_LAT(3), .BR_EXTRA(1), .STAT_W(32))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Both units see identical ID-stage stimulus.
  assign ifb.id_valid    = ifa.id_valid;
  assign ifb.id_rs       = ifa.id_rs;
  assign ifb.id_rt       = ifa.id_rt;
  assign ifb.id_use_rs   = ifa.id_use_rs;
  assign ifb.id_use_rt   = ifa.id_use_rt;
  assign ifb.id_branch   = ifa.id_branch;
  assign ifb.id_wr_en    = ifa.id_wr_en;
  assign ifb.id_rd       = ifa.id_rd;
  assign ifb.id_mem_read = ifa.id_mem_read;
  assign ifb.pipe_hold   = ifa.pipe_hold;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt, br, wr;
    logic [4:0] rd;
    logic       mr, hold;
    logic       stall;
    logic [1:0] cause;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl [25];

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic br,
                              input logic wr, input logic [4:0] rd, input logic mr,
                              input logic hold, input logic stall, input logic [1:0] cause);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.br = br;
    t.wr = wr; t.rd = rd; t.mr = mr; t.hold = hold; t.stall = stall; t.cause = cause;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    ifa.id_valid    = t.v;
    ifa.id_rs       = t.rs;
    ifa.id_rt       = t.rt;
    ifa.id_use_rs   = t.urs;
    ifa.id_use_rt   = t.urt;
    ifa.id_branch   = t.br;
    ifa.id_wr_en    = t.wr;
    ifa.id_rd       = t.rd;
    ifa.id_mem_read = t.mr;
    ifa.pipe_hold   = t.hold;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outs_a();
    return {ifa.pc_write, ifa.if_id_write, ifa.id_ex_flush, ifa.stall_cause};
  endfunction

  vec_t bub, cons_b, cons_a;
  int   n, nc;
  bit   done;

  initial begin
    // args: v rs rt urs urt br wr rd mr hold | stall cause
    tbl[0]  = mk(1, 1, 0, 1, 0, 0, 1, 5, 1, 0, 0, 2'b00); // lw r5
    tbl[1]  = mk(1, 5, 1, 1, 1, 0, 1, 6, 0, 0, 1, 2'b01); // add r6,r5,r1: load-use
    tbl[2]  = mk(1, 5, 1, 1, 1, 0, 1, 6, 0, 0, 0, 2'b00);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00); // bubble drains
    tbl[4]  = mk(1, 2, 0, 1, 0, 0, 1, 5, 1, 0, 0, 2'b00); // lw r5
    tbl[5]  = mk(1, 5, 0, 1, 1, 1, 0, 0, 0, 0, 1, 2'b01); // beq r5,r0
    tbl[6]  = mk(1, 5, 0, 1, 1, 1, 0, 0, 0, 0, 1, 2'b01);
    tbl[7]  = mk(1, 5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00);
    tbl[8]  = mk(1, 1, 2, 1, 1, 0, 1, 5, 0, 0, 0, 2'b00); // add r5
    tbl[9]  = mk(1, 5, 0, 1, 1, 1, 0, 0, 0, 0, 1, 2'b10); // beq r5: branch-data
    tbl[10] = mk(1, 5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00);
    tbl[11] = mk(1, 1, 0, 1, 0, 0, 1, 4, 1, 0, 0, 2'b00); // lw r4
    tbl[12] = mk(1, 1, 2, 1, 1, 0, 1, 4, 0, 0, 0, 2'b00); // add r4 overrides
    tbl[13] = mk(1, 4, 0, 1, 1, 1, 0, 0, 0, 0, 1, 2'b10); // beq r4: one stall
    tbl[14] = mk(1, 4, 0, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00);
    tbl[15] = mk(1, 1, 0, 1, 0, 0, 1, 4, 1, 0, 0, 2'b00); // lw r4
    tbl[16] = mk(1, 1, 2, 1, 1, 0, 1, 4, 0, 0, 0, 2'b00); // add r4
    tbl[17] = mk(1, 4, 1, 1, 1, 0, 1, 8, 0, 0, 0, 2'b00); // ALU consumer of r4
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00); // held bubble
    tbl[19] = mk(1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 2'b00); // lw r0
    tbl[20] = mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00); // beq r0,r0
    tbl[21] = mk(1, 0, 0, 1, 1, 0, 1, 9, 0, 0, 0, 2'b00); // add r9,r0,r0
    tbl[22] = mk(1, 1, 0, 1, 0, 0, 1, 3, 1, 0, 0, 2'b00); // lw r3
    tbl[23] = mk(0, 3, 3, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00); // squashed reader of r3
    tbl[24] = mk(1, 1, 3, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00); // rt=3 unused
    bub    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    cons_b = mk(1, 7, 0, 1, 0, 0, 1, 9, 0, 0, 0, 2'b00);
    cons_a = mk(1, 5, 0, 1, 0, 0, 1, 6, 0, 0, 0, 2'b00);

    drive(bub);
    cyc(); cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outs", {27'd0, outs_a()}, {27'd0, 5'b11000});
    chk("reset_stats", ifa.ld_stall_cnt | ifa.br_stall_cnt, 32'd0);

    for (int i = 0; i < 25; i++) begin
      cyc();
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), {27'd0, outs_a()},
          {27'd0, ~tbl[i].stall, ~tbl[i].stall, tbl[i].stall, tbl[i].cause});
      if (i == 10) begin
        chk("stats_ld", ifa.ld_stall_cnt, STATS ? 32'd3 : 32'd0);
        chk("stats_br", ifa.br_stall_cnt, STATS ? 32'd1 : 32'd0);
      end
    end

    // LOAD_LAT=3 unit: lw r7, then consumer with pipe_hold for 2 mid-stall cycles.
    cyc(); drive(bub); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    drive(mk(1, 1, 0, 1, 0, 0, 1, 7, 1, 0, 0, 2'b00));
    @(negedge clk);
    chk("b_lw_issue", {31'd0, ifb.id_ex_flush}, 32'd0);
    n = 0; nc = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      cyc();
      cons_b.hold = (k == 1 || k == 2);
      drive(cons_b);
      @(negedge clk);
      if (ifb.id_ex_flush) begin
        n++;
        if (ifb.stall_cause == 2'b01 && !ifb.pc_write) nc++;
      end else done = 1'b1;
    end
    chk("b_stall_cycles", n, 32'd5);
    chk("b_stall_cause", nc, 32'd5);
    chk("b_released", {31'd0, done}, 32'd1);

    // Reset asserted while unit A is stalling on a load.
    cyc(); drive(mk(1, 1, 0, 1, 0, 0, 1, 5, 1, 0, 0, 2'b00));
    cyc(); drive(cons_a); rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pre_stall", {27'd0, outs_a()}, {27'd0, 5'b00101});
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_post_outs", {27'd0, outs_a()}, {27'd0, 5'b11000});
    chk("rst_post_stats", ifa.ld_stall_cnt | ifa.br_stall_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
